text_console_writer: RTL and testbench

Character-stream front end for the 32x30 text-mode VGA display. It accepts bytes over a valid/ready handshake, interprets a small set of control codes, and keeps a cursor. It issues single-port writes into the display's character RAM, which the text display stage reads out on the 25 MHz pixel clock. Screen and line clearing are done by internal write sequencers, so software only pushes characters.

---
 rtl/text_console_writer.sv | 194 +++++++++++++++++++
 tb/tb_text_console_writer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// text_console_writer
// Byte-stream front end for the 32-column text-mode display. Accepts characters
// over a valid/ready handshake, interprets LF/CR/BS/FF, keeps a cursor, and
// issues single-port writes into the character RAM. Screen and line clears are
// run by an internal write sequencer, so software only pushes characters.
//
// Ports:
//   clk         system clock (shared with the display stage)
//   reset       synchronous, active-high reset
//   char_in     incoming character code
//   char_valid  char_in is valid this cycle
//   char_ready  writer can accept a character this cycle (registered)
//   ram_we      character RAM write strobe, one cycle per write
//   ram_addr    RAM address {row[4:0], col[4:0]}
//   ram_wdata   RAM write data
//   cursor_row  row where the next printable character lands
//   cursor_col  column where the next printable character lands
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_CLEAR_ALL  | blanking every cell 0..ROWS*32-1, then cursor to (0,0)
// S_IDLE       | ready; one character accepted per cycle
// S_CLEAR_LINE | blanking the 32 cells of the row the cursor just moved to

module text_console_writer #(
   parameter int          ROWS  = 30,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       ram_we,
   output logic [9:0] ram_addr,
   output logic [7:0] ram_wdata,
   output logic [4:0] cursor_row,
   output logic [4:0] cursor_col
);

   typedef enum logic [1:0] {
      S_CLEAR_ALL  = 2'd0,
      S_IDLE       = 2'd1,
      S_CLEAR_LINE = 2'd2
   } state_t;

   localparam logic [10:0] CELLS      = 11'(ROWS * 32);
   localparam logic [10:0] LINE_CELLS = 11'd32;
   localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);

   localparam logic [7:0] C_BS = 8'h08;
   localparam logic [7:0] C_LF = 8'h0A;
   localparam logic [7:0] C_FF = 8'h0C;
   localparam logic [7:0] C_CR = 8'h0D;

   state_t      state, state_nx;
   logic [10:0] cnt, cnt_nx;
   logic        we_nx, ready_nx;
   logic [9:0]  addr_nx;
   logic [7:0]  wdata_nx;
   logic [4:0]  row_nx, col_nx;

   logic        accept;
   logic        is_print;
   logic        row_adv;
   logic [4:0]  adv_row;

   assign accept   = char_valid && char_ready && (state == S_IDLE);
   assign is_print = (char_in >= 8'h20) && (char_in <= 8'h7E);
   // A printable in the last column or an LF moves to a fresh line.
   assign row_adv  = (is_print && (cursor_col == 5'd31)) || (char_in == C_LF);
   // No scrolling: the bottom row wraps to the top.
   assign adv_row  = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_CLEAR_ALL;
         cnt        <= '0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= BLANK;
         char_ready <= 1'b0;
         cursor_row <= '0;
         cursor_col <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         ram_we     <= we_nx;
         ram_addr   <= addr_nx;
         ram_wdata  <= wdata_nx;
         char_ready <= ready_nx;
         cursor_row <= row_nx;
         cursor_col <= col_nx;
      end
   end

   // Next state
   always_comb begin
      state_nx = state;
      case (state)
         S_CLEAR_ALL: begin
            if (cnt == CELLS) state_nx = S_IDLE;
         end
         S_CLEAR_LINE: begin
            if (cnt == LINE_CELLS) state_nx = S_IDLE;
         end
         S_IDLE: begin
            if (accept) begin
               if (char_in == C_FF)  state_nx = S_CLEAR_ALL;
               else if (row_adv)     state_nx = S_CLEAR_LINE;
            end
         end
         default: state_nx = S_CLEAR_ALL;
      endcase
   end

   // Next values of the registered outputs and the clear counter.
   // The counter runs one past the last cell so the final cycle can drop
   // ram_we and raise char_ready on the edge after the last write.
   always_comb begin
      cnt_nx   = cnt;
      we_nx    = 1'b0;
      addr_nx  = ram_addr;
      wdata_nx = ram_wdata;
      ready_nx = char_ready;
      row_nx   = cursor_row;
      col_nx   = cursor_col;
      case (state)
         S_CLEAR_ALL: begin
            if (cnt == CELLS) begin
               cnt_nx   = '0;
               ready_nx = 1'b1;
               row_nx   = '0;
               col_nx   = '0;
            end else begin
               we_nx    = 1'b1;
               addr_nx  = cnt[9:0];
               wdata_nx = BLANK;
               cnt_nx   = cnt + 11'd1;
            end
         end
         S_CLEAR_LINE: begin
            if (cnt == LINE_CELLS) begin
               cnt_nx   = '0;
               ready_nx = 1'b1;
            end else begin
               we_nx    = 1'b1;
               addr_nx  = {cursor_row, cnt[4:0]};
               wdata_nx = BLANK;
               cnt_nx   = cnt + 11'd1;
            end
         end
         S_IDLE: begin
            if (accept) begin
               cnt_nx = '0;
               if (is_print) begin
                  we_nx    = 1'b1;
                  addr_nx  = {cursor_row, cursor_col};
                  wdata_nx = char_in;
                  if (cursor_col == 5'd31) begin
                     row_nx   = adv_row;
                     col_nx   = '0;
                     ready_nx = 1'b0;
                  end else begin
                     col_nx = cursor_col + 5'd1;
                  end
               end else if (char_in == C_LF) begin
                  row_nx   = adv_row;
                  col_nx   = '0;
                  ready_nx = 1'b0;
               end else if (char_in == C_CR) begin
                  col_nx = '0;
               end else if (char_in == C_BS) begin
                  if (cursor_col != 5'd0) begin
                     col_nx   = cursor_col - 5'd1;
                     we_nx    = 1'b1;
                     addr_nx  = {cursor_row, cursor_col - 5'd1};
                     wdata_nx = BLANK;
                  end
               end else if (char_in == C_FF) begin
                  // Cursor stays put until the clear finishes.
                  ready_nx = 1'b0;
               end
            end
         end
         default: begin
            cnt_nx   = '0;
            ready_nx = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;

   localparam int         ROWS  = 30;
   localparam int         CELLS = ROWS * 32;
   localparam logic [7:0] BLANK = 8'h20;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] char_in;
   logic       char_valid;
   logic       char_ready;
   logic       ram_we;
   logic [9:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [4:0] cursor_row;
   logic [4:0] cursor_col;

   int checks   = 0;
   int failures = 0;

   text_console_writer #(.ROWS(ROWS), .BLANK(BLANK)) dut (
      .clk        (clk),
      .reset      (reset),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col)
   );

   always #20 clk = ~clk;

   // Write monitor: shadow RAM, ordered write log, running write count
   logic [7:0]  shadow [0:1023];
   logic [17:0] wq [$];
   int          wcount = 0;

   always @(posedge clk) begin
      #1;
      if (ram_we === 1'b1) begin
         wq.push_back({ram_addr, ram_wdata});
         shadow[ram_addr] = ram_wdata;
         wcount++;
      end
   end

   // Reference model: screen contents and cursor as plain integers
   logic [7:0] m_screen [0:CELLS-1];
   int         m_row, m_col;

   task automatic model_blank_all();
      for (int k = 0; k < CELLS; k++) m_screen[k] = BLANK;
      m_row = 0;
      m_col = 0;
   endtask

   // Applies one accepted character. Returns the write expected on the accept
   // edge, the cursor expected on that edge, and how many cycles char_ready
   // stays low afterwards (0 if it stays high).
   task automatic model_apply(input logic [7:0] c, output logic e_we,
                              output logic [9:0] e_addr, output logic [7:0] e_data,
                              output int e_busy, output int e_row, output int e_col);
      bit adv;
      e_we = 1'b0; e_addr = '0; e_data = '0; e_busy = 0; adv = 0;
      if (c >= 8'h20 && c <= 8'h7E) begin
         e_we   = 1'b1;
         e_addr = 10'(m_row * 32 + m_col);
         e_data = c;
         m_screen[m_row * 32 + m_col] = c;
         if (m_col == 31) adv = 1;
         else m_col = m_col + 1;
      end else if (c == 8'h0A) begin
         adv = 1;
      end else if (c == 8'h0D) begin
         m_col = 0;
      end else if (c == 8'h08) begin
         if (m_col > 0) begin
            m_col  = m_col - 1;
            e_we   = 1'b1;
            e_addr = 10'(m_row * 32 + m_col);
            e_data = BLANK;
            m_screen[m_row * 32 + m_col] = BLANK;
         end
      end else if (c == 8'h0C) begin
         e_busy = CELLS + 1;
         e_row  = m_row;
         e_col  = m_col;
         model_blank_all();
         return;
      end
      if (adv) begin
         m_col = 0;
         m_row = (m_row + 1) % ROWS;
         for (int k = 0; k < 32; k++) m_screen[m_row * 32 + k] = BLANK;
         e_busy = 33;
      end
      e_row = m_row;
      e_col = m_col;
   endtask

   function automatic logic [7:0] pick_char();
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 99);
      if (r < 70)      c = 8'($urandom_range(32, 126));
      else if (r < 78) c = 8'h0A;
      else if (r < 83) c = 8'h0D;
      else if (r < 91) c = 8'h08;
      else if (r < 99) begin
         c = 8'($urandom_range(0, 255));
         while ((c >= 8'h20 && c <= 8'h7E) || c == 8'h0A || c == 8'h0D ||
                c == 8'h08 || c == 8'h0C)
            c = 8'($urandom_range(0, 255));
      end else c = 8'h0C;
      return c;
   endfunction

   // Counts falling edges until char_ready is seen high; aborts on timeout.
   task automatic wait_ready(input int budget, output int n);
      n = 0;
      while (char_ready !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (char_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL wait_ready_timeout got=%0d cycles without char_ready, exp<=%0d", n, budget);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $fatal(1, "char_ready never returned");
      end
   endtask

   // Pushes one character (char_ready must be high) and waits until ready again.
   task automatic drive_char(input logic [7:0] c);
      logic e_we; logic [9:0] e_addr; logic [7:0] e_data;
      int e_busy, e_row, e_col, n;
      char_in    = c;
      char_valid = 1'b1;
      model_apply(c, e_we, e_addr, e_data, e_busy, e_row, e_col);
      @(negedge clk);
      char_valid = 1'b0;
      wait_ready(2000, n);
   endtask

   task automatic test_reset();
      reset = 1'b1; char_valid = 1'b0; char_in = 8'h00;
      repeat (3) @(negedge clk);
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", ram_we); end
      checks++; if (ram_addr !== 10'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", ram_addr); end
      checks++; if (ram_wdata !== BLANK) begin failures++; $display("FAIL reset_wdata got=%0h exp=%0h", ram_wdata, BLANK); end
      checks++; if (char_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", char_ready); end
      checks++; if (cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
         failures++; $display("FAIL reset_cursor got=(%0d,%0d) exp=(0,0)", cursor_row, cursor_col); end
   endtask

   task automatic test_power_clear();
      int n, bad;
      wq.delete();
      reset = 1'b0;
      wait_ready(2000, n);
      checks++; if (n != CELLS + 1) begin failures++; $display("FAIL pwr_ready_edge got=%0d exp=%0d", n, CELLS + 1); end
      checks++; if (wq.size() != CELLS) begin failures++; $display("FAIL pwr_write_count got=%0d exp=%0d", wq.size(), CELLS); end
      bad = 0;
      foreach (wq[k]) if (wq[k] !== {10'(k), BLANK}) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL pwr_sequence got=%0d bad writes exp=0", bad); end
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL pwr_we_after got=%0b exp=0", ram_we); end
      checks++; if (cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
         failures++; $display("FAIL pwr_cursor got=(%0d,%0d) exp=(0,0)", cursor_row, cursor_col); end
      model_blank_all();
   endtask

   task automatic test_back_to_back();
      logic e_we; logic [9:0] e_addr; logic [7:0] e_data;
      int e_busy, e_row, e_col;
      char_in = 8'h48; char_valid = 1'b1;
      model_apply(8'h48, e_we, e_addr, e_data, e_busy, e_row, e_col);
      @(negedge clk);
      checks++; if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 10'h000, 8'h48}) begin
         failures++; $display("FAIL b2b_first got=(%0b,%0h,%0h) exp=(1,000,48)", ram_we, ram_addr, ram_wdata); end
      char_in = 8'h49;
      model_apply(8'h49, e_we, e_addr, e_data, e_busy, e_row, e_col);
      @(negedge clk);
      char_valid = 1'b0;
      checks++; if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 10'h001, 8'h49}) begin
         failures++; $display("FAIL b2b_second got=(%0b,%0h,%0h) exp=(1,001,49)", ram_we, ram_addr, ram_wdata); end
      checks++; if (cursor_col !== 5'd2 || char_ready !== 1'b1) begin
         failures++; $display("FAIL b2b_col_ready got=(%0d,%0b) exp=(2,1)", cursor_col, char_ready); end
      @(negedge clk);
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL b2b_we_drop got=%0b exp=0", ram_we); end
   endtask

   task automatic test_wrap_col();
      logic e_we; logic [9:0] e_addr; logic [7:0] e_data;
      int e_busy, e_row, e_col, n, bad;
      drive_char(8'h0D);
      repeat (3) drive_char(8'h0A);
      repeat (31) drive_char(8'($urandom_range(32, 126)));
      checks++; if (cursor_row !== 5'd3 || cursor_col !== 5'd31) begin
         failures++; $display("FAIL wrap_setup got=(%0d,%0d) exp=(3,31)", cursor_row, cursor_col); end
      wq.delete();
      char_in = 8'h5A; char_valid = 1'b1;
      model_apply(8'h5A, e_we, e_addr, e_data, e_busy, e_row, e_col);
      @(negedge clk);
      char_valid = 1'b0;
      checks++; if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 10'h07F, 8'h5A}) begin
         failures++; $display("FAIL wrap_write got=(%0b,%0h,%0h) exp=(1,07f,5a)", ram_we, ram_addr, ram_wdata); end
      checks++; if (cursor_row !== 5'd4 || cursor_col !== 5'd0 || char_ready !== 1'b0) begin
         failures++; $display("FAIL wrap_e0 got=(%0d,%0d,rdy %0b) exp=(4,0,rdy 0)", cursor_row, cursor_col, char_ready); end
      wait_ready(100, n);
      checks++; if (n != 33) begin failures++; $display("FAIL wrap_busy got=%0d exp=33", n); end
      bad = 0;
      for (int k = 1; k < wq.size(); k++) if (wq[k] !== {10'(128 + k - 1), BLANK}) bad++;
      checks++; if (wq.size() != 33 || bad != 0) begin
         failures++; $display("FAIL wrap_clear got=%0d writes %0d bad exp=33 writes 0 bad", wq.size(), bad); end
   endtask

   task automatic test_lf_wrap();
      logic e_we; logic [9:0] e_addr; logic [7:0] e_data;
      int e_busy, e_row, e_col, n, bad;
      repeat (25) drive_char(8'h0A);
      checks++; if (cursor_row !== 5'd29) begin failures++; $display("FAIL lf_setup got=%0d exp=29", cursor_row); end
      wq.delete();
      char_in = 8'h0A; char_valid = 1'b1;
      model_apply(8'h0A, e_we, e_addr, e_data, e_busy, e_row, e_col);
      @(negedge clk);
      char_valid = 1'b0;
      checks++; if (ram_we !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
         failures++; $display("FAIL lf_e0 got=(we %0b,%0d,%0d) exp=(we 0,0,0)", ram_we, cursor_row, cursor_col); end
      wait_ready(100, n);
      checks++; if (n != 33) begin failures++; $display("FAIL lf_busy got=%0d exp=33", n); end
      bad = 0;
      foreach (wq[k]) if (wq[k] !== {10'(k), BLANK}) bad++;
      checks++; if (wq.size() != 32 || bad != 0) begin
         failures++; $display("FAIL lf_clear got=%0d writes %0d bad exp=32 writes 0 bad", wq.size(), bad); end
   endtask

   task automatic test_backspace();
      logic e_we; logic [9:0] e_addr; logic [7:0] e_data;
      int e_busy, e_row, e_col, w0;
      repeat (5) drive_char(8'($urandom_range(33, 126)));
      char_in = 8'h08; char_valid = 1'b1;
      model_apply(8'h08, e_we, e_addr, e_data, e_busy, e_row, e_col);
      @(negedge clk);
      char_valid = 1'b0;
      checks++; if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 10'h004, BLANK} || cursor_col !== 5'd4) begin
         failures++; $display("FAIL bs_write got=(%0b,%0h,%0h,col %0d) exp=(1,004,20,col 4)",
                              ram_we, ram_addr, ram_wdata, cursor_col); end
      drive_char(8'h0D);
      w0 = wcount;
      char_in = 8'h08; char_valid = 1'b1;
      model_apply(8'h08, e_we, e_addr, e_data, e_busy, e_row, e_col);
      @(negedge clk);
      char_in = 8'h07;
      model_apply(8'h07, e_we, e_addr, e_data, e_busy, e_row, e_col);
      @(negedge clk);
      char_valid = 1'b0;
      checks++; if (wcount != w0 || cursor_row !== 5'd0 || cursor_col !== 5'd0 || char_ready !== 1'b1) begin
         failures++; $display("FAIL bs_col0_bel got=(%0d writes,%0d,%0d,rdy %0b) exp=(0 writes,0,0,rdy 1)",
                              wcount - w0, cursor_row, cursor_col, char_ready); end
      checks++; if (shadow[4] !== BLANK) begin failures++; $display("FAIL bs_cell got=%0h exp=20", shadow[4]); end
   endtask

   task automatic test_random();
      logic e_we; logic [9:0] e_addr; logic [7:0] e_data;
      logic [7:0] c;
      int e_busy, e_row, e_col, n, w0, bad;
      int errs_e0 = 0, errs_busy = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            char_valid = 1'b0;
            @(negedge clk);
            checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rnd_idle_we i=%0d got=%0b exp=0", i, ram_we); end
         end
         c = pick_char();
         w0 = wcount;
         char_in = c; char_valid = 1'b1;
         model_apply(c, e_we, e_addr, e_data, e_busy, e_row, e_col);
         @(negedge clk);
         checks++;
         if (ram_we !== e_we || (e_we && (ram_addr !== e_addr || ram_wdata !== e_data)) ||
             cursor_row !== 5'(e_row) || cursor_col !== 5'(e_col) ||
             char_ready !== (e_busy == 0) || (wcount - w0) != int'(e_we)) begin
            failures++;
            if (errs_e0++ < 5)
               $display("FAIL rnd_accept i=%0d c=%0h got=(we %0b,%0h,%0h,%0d,%0d,rdy %0b) exp=(we %0b,%0h,%0h,%0d,%0d,rdy %0b)",
                        i, c, ram_we, ram_addr, ram_wdata, cursor_row, cursor_col, char_ready,
                        e_we, e_addr, e_data, e_row, e_col, e_busy == 0);
         end
         if (e_busy != 0) begin
            char_in = 8'($urandom_range(32, 126));   // offered while busy, must be ignored
            wait_ready(2000, n);
            checks++;
            if (n != e_busy || cursor_row !== 5'(m_row) || cursor_col !== 5'(m_col) ||
                (wcount - w0) != int'(e_we) + e_busy - 1) begin
               failures++;
               if (errs_busy++ < 5)
                  $display("FAIL rnd_busy i=%0d c=%0h got=(%0d cyc,%0d,%0d,%0d writes) exp=(%0d cyc,%0d,%0d,%0d writes)",
                           i, c, n, cursor_row, cursor_col, wcount - w0,
                           e_busy, m_row, m_col, int'(e_we) + e_busy - 1);
            end
         end
      end
      char_valid = 1'b0;
      @(negedge clk);
      bad = 0;
      for (int k = 0; k < CELLS; k++) if (shadow[k] !== m_screen[k]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL rnd_screen got=%0d differing cells exp=0", bad); end
   endtask

   task automatic test_reset_mid_clear();
      logic e_we; logic [9:0] e_addr; logic [7:0] e_data;
      int e_busy, e_row, e_col, n, k, bad;
      wq.delete();
      char_in = 8'h0C; char_valid = 1'b1;
      model_apply(8'h0C, e_we, e_addr, e_data, e_busy, e_row, e_col);
      @(negedge clk);
      char_valid = 1'b0;
      checks++; if (ram_we !== 1'b0 || char_ready !== 1'b0) begin
         failures++; $display("FAIL ff_e0 got=(we %0b,rdy %0b) exp=(we 0,rdy 0)", ram_we, char_ready); end
      k = 0;
      while (wq.size() < 100 && k < 500) begin
         @(negedge clk);
         k++;
      end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (ram_we !== 1'b0 || wq.size() != 100 || char_ready !== 1'b0) begin
         failures++; $display("FAIL rst_abandon got=(we %0b,%0d writes,rdy %0b) exp=(we 0,100 writes,rdy 0)",
                              ram_we, wq.size(), char_ready); end
      repeat (2) @(negedge clk);
      wq.delete();
      reset = 1'b0;
      wait_ready(2000, n);
      bad = 0;
      foreach (wq[j]) if (wq[j] !== {10'(j), BLANK}) bad++;
      checks++; if (n != CELLS + 1 || wq.size() != CELLS || bad != 0) begin
         failures++; $display("FAIL rst_restart got=(%0d cyc,%0d writes,%0d bad) exp=(%0d cyc,%0d writes,0 bad)",
                              n, wq.size(), bad, CELLS + 1, CELLS); end
      model_blank_all();
      checks++; if (cursor_row !== 5'd0 || cursor_col !== 5'd0 || char_ready !== 1'b1) begin
         failures++; $display("FAIL rst_cursor got=(%0d,%0d,rdy %0b) exp=(0,0,rdy 1)", cursor_row, cursor_col, char_ready); end
   endtask

   initial begin
      test_reset();
      test_power_clear();
      test_back_to_back();
      test_wrap_col();
      test_lf_wrap();
      test_backspace();
      test_random();
      test_reset_mid_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
